svnet_dot_product: RTL and testbench

- Consumer stage that drains a register FIFO of packed {weight, pixel} operand pairs.
- Performs a signed multiply-accumulate over LENGTH consecutive pairs.
- Pushes each finished sum into a downstream register FIFO using the same free_space/write convention.
- Forms the inner-product core of a convolution lane; upstream and downstream FIFOs are instantiated by the parent.

---
 rtl/svnet_dot_product.sv | 120 ++++++++++++
 tb/tb_svnet_dot_product.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svnet_dot_product.sv
// svnet_dot_product: signed multiply-accumulate consumer stage.
// Pops LENGTH packed {weight, pixel} pairs from an upstream register FIFO,
// accumulates their full-precision products, then pushes the finished sum into
// a downstream register FIFO. Both FIFOs use the occupancy/free-space plus
// single-strobe convention and live in the parent.
// Optional build macro: SVNET_DOT_PRODUCT_RELU_EN clamps negative results to
// zero on out_write_data. The accumulator is left unmodified.
module svnet_dot_product #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 9,
    parameter int IN_DEPTH   = 2,
    parameter int OUT_DEPTH  = 2,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(LENGTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(IN_DEPTH):0]      in_used_space,
    input  logic [2*DATA_WIDTH-1:0]        in_read_data,
    output logic                           in_read,
    input  logic [$clog2(OUT_DEPTH):0]     out_free_space,
    output logic                           out_write,
    output logic [ACC_WIDTH-1:0]           out_write_data,
    output logic                           busy
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    // LENGTH == 1 still needs a one-bit counter so the vector is never empty.
    localparam int CNT_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LENGTH - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic signed [DATA_WIDTH-1:0]  weight;
    logic signed [DATA_WIDTH-1:0]  pixel;
    logic signed [PROD_W-1:0]      product;
    logic signed [ACC_WIDTH-1:0]   product_ext;
    logic signed [ACC_WIDTH-1:0]   result;

    assign weight      = in_read_data[PROD_W-1:DATA_WIDTH];
    assign pixel       = in_read_data[DATA_WIDTH-1:0];
    // Both operands are signed, so the product is a full two's-complement result.
    assign product     = weight * pixel;
    assign product_ext = {{(ACC_WIDTH - PROD_W){product[PROD_W-1]}}, product};

`ifdef SVNET_DOT_PRODUCT_RELU_EN
    // Clamp negative sums at the output only; acc_q keeps the true value.
    assign result = acc_q[ACC_WIDTH-1] ? '0 : acc_q;
`else
    assign result = acc_q;
`endif

    assign busy = (count_q != '0) || (state_q == EMIT);

    // Next-state, datapath and FIFO strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        acc_d          = acc_q;
        count_d        = count_q;
        in_read        = 1'b0;
        out_write      = 1'b0;
        out_write_data = '0;
        case (state_q)
            ACCUM: begin
                // rst gates the pop so nothing is consumed while the stage is held.
                in_read = !rst && (in_used_space != '0);
                if (in_read) begin
                    acc_d = acc_q + product_ext;
                    if (count_q == LAST_COUNT) begin
                        count_d = '0;
                        state_d = EMIT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                out_write      = (out_free_space != '0);
                out_write_data = result;
                if (out_write) begin
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, accumulator and pair counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    // Handshake and counter invariants.
    a_pop_needs_data : assert property (@(posedge clk) disable iff (rst)
        in_read |-> (in_used_space != '0));
    a_push_needs_space : assert property (@(posedge clk) disable iff (rst)
        out_write |-> (out_free_space != '0));
    a_count_in_range : assert property (@(posedge clk) disable iff (rst)
        int'(count_q) < LENGTH);

endmodule

// File: tb/tb_svnet_dot_product.sv
// Self-checking bench for svnet_dot_product: two instances (LENGTH 3 and 9),
// directed vectors with hand-computed sums, scoreboard queues drained by a
// negedge monitor.
module tb_svnet_dot_product;

    localparam int DW  = 8;
    localparam int L3  = 3;
    localparam int L9  = 9;
    localparam int AW3 = 2 * DW + $clog2(L3) + 1;
    localparam int AW9 = 2 * DW + $clog2(L9) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;

    logic [1:0]     used3, free3, used9, free9;
    logic [15:0]    data3, data9;
    logic           rd3, wr3, busy3, rd9, wr9, busy9;
    logic [AW3-1:0] wd3;
    logic [AW9-1:0] wd9;

    int     checks   = 0;
    int     failures = 0;
    int     cycle    = 0;
    longint exp3[$];
    longint exp9[$];
    int     wcyc3[$];

    svnet_dot_product #(.DATA_WIDTH(DW), .LENGTH(L3), .IN_DEPTH(2), .OUT_DEPTH(2)) dut3 (
        .clk(clk), .rst(rst),
        .in_used_space(used3), .in_read_data(data3), .in_read(rd3),
        .out_free_space(free3), .out_write(wr3), .out_write_data(wd3),
        .busy(busy3)
    );

    svnet_dot_product #(.DATA_WIDTH(DW), .LENGTH(L9), .IN_DEPTH(2), .OUT_DEPTH(2)) dut9 (
        .clk(clk), .rst(rst),
        .in_used_space(used9), .in_read_data(data9), .in_read(rd9),
        .out_free_space(free9), .out_write(wr9), .out_write_data(wd9),
        .busy(busy9)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic longint relu(input longint v);
`ifdef SVNET_DOT_PRODUCT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Scoreboard monitor: protocol checks and result comparison at negedge.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_overlap3", longint'(rd3 & wr3), 0);
            check("rd_wr_overlap9", longint'(rd9 & wr9), 0);
            if (rd3) check("rd3_without_data", longint'(used3 != 0), 1);
            if (wr3) check("wr3_without_space", longint'(free3 != 0), 1);
            if (wr3) begin
                wcyc3.push_back(cycle);
                if (exp3.size() == 0) check("unexpected_write3", longint'($signed(wd3)), -999999);
                else check("result3", longint'($signed(wd3)), exp3.pop_front());
            end
            if (wr9) begin
                if (exp9.size() == 0) check("unexpected_write9", longint'($signed(wd9)), -999999);
                else check("result9", longint'($signed(wd9)), exp9.pop_front());
            end
        end
    end

    // Present one pair and wait (bounded) until dut3 pops it. Called at posedge+1.
    task automatic feed3(input int w, input int p);
        used3 = 2'd1;
        data3 = {8'(w), 8'(p)};
        for (int n = 0; n < 64; n++) begin
            #1;
            if (rd3) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("feed3_timeout", 1, 0);
    endtask

    task automatic feed9(input int w, input int p);
        used9 = 2'd1;
        data9 = {8'(w), 8'(p)};
        for (int n = 0; n < 64; n++) begin
            #1;
            if (rd9) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("feed9_timeout", 1, 0);
    endtask

    task automatic vec3(input int w0, input int p0, input int w1, input int p1,
                        input int w2, input int p2, input longint expect_sum);
        exp3.push_back(relu(expect_sum));
        feed3(w0, p0);
        feed3(w1, p1);
        feed3(w2, p2);
        used3 = 2'd0;
    endtask

    task automatic vec9(input int w, input int p, input longint expect_sum);
        exp9.push_back(relu(expect_sum));
        for (int i = 0; i < L9; i++) feed9(w, p);
        used9 = 2'd0;
    endtask

    // Starve dut3 for n cycles mid-vector: no pops, partial sum still held.
    task automatic idle3(input int n);
        used3 = 2'd0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("starve_no_read", longint'(rd3), 0);
            check("starve_busy", longint'(busy3), 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        // Reset state: inputs active, outputs must still be quiet.
        used3 = 2'd1; data3 = 16'h0203; free3 = 2'd2;
        used9 = 2'd1; data9 = 16'h0101; free9 = 2'd2;
        #2;
        check("reset_in_read3", longint'(rd3), 0);
        check("reset_out_write3", longint'(wr3), 0);
        check("reset_busy3", longint'(busy3), 0);
        check("reset_data3", longint'(wd3), 0);
        check("reset_in_read9", longint'(rd9), 0);
        @(posedge clk); @(posedge clk); #1;
        used3 = 2'd0; used9 = 2'd0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic sum: 2*3 + (-4)*5 + 1*1 = -13, popped back-to-back.
        exp3.push_back(relu(-13));
        used3 = 2'd1; data3 = {8'(2), 8'(3)};
        #1; check("basic_pop0", longint'(rd3), 1); @(posedge clk); #1;
        data3 = {8'(-4), 8'(5)};
        #1; check("basic_pop1", longint'(rd3), 1); @(posedge clk); #1;
        data3 = {8'(1), 8'(1)};
        #1; check("basic_pop2", longint'(rd3), 1); @(posedge clk); #1;
        #1;
        check("basic_write_next_cycle", longint'(wr3), 1);
        check("basic_no_read_in_emit", longint'(rd3), 0);
        check("basic_busy_in_emit", longint'(busy3), 1);
        @(posedge clk); #1;
        used3 = 2'd0;
        #1; check("basic_idle_after", longint'(busy3), 0);
        @(posedge clk); #1;

        // Input starvation: same vector with gaps gives the same sum.
        exp3.push_back(relu(-13));
        feed3(2, 3);
        idle3(2);
        feed3(-4, 5);
        idle3(2);
        feed3(1, 1);
        used3 = 2'd0;
        @(posedge clk); #1;

        // Output backpressure: 1*2 + 3*4 + 5*6 = 44 held for 5 cycles.
        exp3.push_back(relu(44));
        feed3(1, 2);
        feed3(3, 4);
        free3 = 2'd0;
        feed3(5, 6);
        used3 = 2'd1; data3 = {8'(1), 8'(1)};
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_no_write", longint'(wr3), 0);
            check("bp_no_read", longint'(rd3), 0);
            check("bp_busy", longint'(busy3), 1);
            @(posedge clk); #1;
        end
        free3 = 2'd1;
        #1; check("bp_single_write", longint'(wr3), 1);
        @(posedge clk); #1;
        #1; check("bp_read_resumes", longint'(rd3), 1);
        check("bp_write_once", longint'(wr3), 0);
        exp3.push_back(relu(3));
        feed3(1, 1);
        feed3(1, 1);
        feed3(1, 1);
        used3 = 2'd0;
        free3 = 2'd2;
        @(posedge clk); #1;

        // Reset mid-accumulation after 2 of 3 pops (partial 98 must vanish).
        feed3(7, 7);
        feed3(7, 7);
        rst = 1'b1;
        data3 = {8'(7), 8'(7)};
        #1;
        check("midrst_in_read", longint'(rd3), 0);
        check("midrst_out_write", longint'(wr3), 0);
        check("midrst_busy", longint'(busy3), 0);
        check("midrst_data", longint'(wd3), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        used3 = 2'd0;
        @(posedge clk); #1;

        // Reset while holding EMIT: the stalled 75 is discarded.
        free3 = 2'd0;
        feed3(5, 5); feed3(5, 5); feed3(5, 5);
        used3 = 2'd0;
        #1; check("emit_hold_data", longint'($signed(wd3)), 75);
        rst = 1'b1;
        #1;
        check("emitrst_data", longint'(wd3), 0);
        check("emitrst_busy", longint'(busy3), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        free3 = 2'd2;
        @(posedge clk); #1;
        vec3(1, 1, 1, 1, 1, 1, 3);
        @(posedge clk); #1;

        // Pipelined stream: four vectors, results every 4 cycles.
        for (int n = 0; n < 50 && exp3.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        wcyc3.delete();
        vec3(1, 2, 3, 4, 5, 6, 44);
        vec3(-1, 1, -2, 2, -3, 3, -14);
        vec3(127, 127, 127, -128, 0, 5, -127);
        vec3(-128, -128, -128, -128, -128, -128, 49152);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pipe_result_count", longint'(wcyc3.size()), 4);
        if (wcyc3.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("pipe_period", longint'(wcyc3[i] - wcyc3[i-1]), 4);
        end

        // Extreme operands on the LENGTH=9 instance.
        vec9(-128, -128, 147456);
        vec9(-128, 127, -146304);

        // Drain both scoreboards with a bounded wait.
        for (int n = 0; n < 200 && (exp3.size() + exp9.size()) != 0; n++) begin
            @(posedge clk); #1;
        end
        check("scoreboard_drained", longint'(exp3.size() + exp9.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
